grid_reg_arbiter: RTL and testbench
===================================

# grid_reg_arbiter

AXI4-Lite master that shares the 4-register grid_controller_32_half slave (S00_AXI, registers at offsets 0x0/0x4/0x8/0xC) between two requesters, e.g. the processor bridge and the game-logic engine. Each requester issues single-register read or write commands over a valid/ready port. The block arbitrates round-robin, runs exactly one AXI4-Lite transaction at a time, and returns a one-cycle response pulse to the granted requester.

## Interface
- C_S_AXI_ADDR_WIDTH, 4: master address width; the slave decodes bits [3:2].
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_BASE_ADDR, 0: value added to {idx,2'b00} to form AWADDR/ARADDR.
- ACLK in 1: single clock; all logic on rising edge.
- ARESETN in 1: reset, synchronous, active-low.
- reqN_valid in 1 (N=0,1): command valid.
- reqN_ready out 1: command accepted when valid&ready.
- reqN_write in 1: 1 = write, 0 = read.
- reqN_idx in 2: register index 0..3.
- reqN_wdata in 32: write data, ignored for reads.
- rspN_valid out 1: one-cycle response pulse; no backpressure.
- rspN_rdata out 32: read data; 0 for writes.
- rspN_err out 1: BRESP/RRESP[1] (SLVERR or DECERR).
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master channels. prot = 3'b000; wstrb = 4'hF.

## Operation
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: grant = the valid port. If both ports are valid, grant the port not granted last (last_grant). reqN_ready = (state==IDLE) & grant==N, combinational from reqN_valid. On accept, register write, idx, wdata and granted port, update last_grant, and go to WR or RD_ADDR.
- WR: assert awvalid and wvalid together. Drop each independently after its own handshake, tracked by aw_done/w_done flags. Go to WR_RESP when both are done; same-cycle completion of both is legal.
- WR_RESP: bready=1. On bvalid, capture err=bresp[1] and go to RESP.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and err=rresp[1], then go to RESP.
- RESP: rspN_valid=1 for the granted port only, for exactly one cycle, then go to IDLE.
- rspN_rdata and rspN_err hold the last captured values between pulses. They are valid only while rspN_valid is high.
- Address and data stay stable while the corresponding valid is high. AXI valids never drop before their handshake.
- No transaction abort or timeout. A stalled slave stalls both requesters.

## Timing
- Reset (ARESETN low at a clock edge):
  - state=IDLE, last_grant=1 so port 0 wins the first tie.
  - aw/w/ar valids, bready, rready, reqN_ready = 0; rspN_valid=0, rspN_rdata=0, rspN_err=0.
- Reset mid-transaction abandons the transaction with no response pulse. The slave shares ARESETN, so both reset together.
- Zero-wait slave, accept at cycle 0:
  - Write: AW/W handshake at cycle 1, bvalid seen at cycle 2, rsp pulse at cycle 3, next accept at cycle 4.
  - Read: AR handshake at cycle 1, R handshake at cycle 2, rsp pulse at cycle 3.
- Each slave wait cycle on any channel adds one cycle.
- Minimum accept-to-accept spacing is 4 cycles.
- A request that arrives during the RESP cycle can be accepted in the following IDLE cycle.

## Test plan
- Port 0 writes idx 0..3 with 0x1,0x2,0x3,0x4 using a zero-wait slave. Required: AWADDR 0x0,0x4,0x8,0xC; each rsp0_valid exactly 3 cycles after accept; err=0.
- Port 1 reads idx 0..3 after the writes above. Required: rsp1_rdata = 0x1,0x2,0x3,0x4 in order; rsp0_valid never asserts.
- Both ports hold valid continuously for 6 commands after reset. Required: grant order 0,1,0,1,0,1.
- Slave delays awready 3 cycles and returns wready immediately. Required: wvalid drops after 1 cycle; awvalid holds 4 cycles; bready rises only after both handshakes; rsp pulse at cycle 6.
- Slave returns RRESP=2'b10 with rdata 0xDEADBEEF. Required: rsp0_err=1, rsp0_rdata=0xDEADBEEF; next command proceeds normally.
- Assert ARESETN=0 for one cycle while in WR_RESP. Required: all outputs at reset values next cycle, no rsp pulse, port 0 wins the next tie.

Source files
------------

// File: rtl/grid_reg_arbiter.sv
// grid_reg_arbiter: round-robin arbiter sharing one AXI4-Lite register slave between two requesters
module grid_reg_arbiter #(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              req0_valid,
    output logic                              req0_ready,
    input  logic                              req0_write,
    input  logic [1:0]                        req0_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     req0_wdata,
    input  logic                              req1_valid,
    output logic                              req1_ready,
    input  logic                              req1_write,
    input  logic [1:0]                        req1_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     req1_wdata,
    output logic                              rsp0_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp0_rdata,
    output logic                              rsp0_err,
    output logic                              rsp1_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp1_rdata,
    output logic                              rsp1_err,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
    state_t state, state_nxt;
    logic last_grant, grant, accept, aw_done, w_done, err_q;
    logic [1:0] idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0] addr;
    logic unused_resp;
    // last_grant doubles as the port owning the in-flight transaction
    assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    assign accept = (state == IDLE) & (req0_valid | req1_valid);
    assign addr = C_BASE_ADDR + C_S_AXI_ADDR_WIDTH'({idx_q, 2'b00});
    assign m_axi_awaddr = addr;
    assign m_axi_araddr = addr;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb = '1;
    assign m_axi_wdata = wdata_q;
    assign rsp0_rdata = rdata_q;
    assign rsp1_rdata = rdata_q;
    assign rsp0_err = err_q;
    assign rsp1_err = err_q;
    assign unused_resp = ^{m_axi_bresp[0], m_axi_rresp[0]};
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (grant ? req1_write : req0_write) ? WR : RD_ADDR;
            WR:      if ((aw_done | m_axi_awready) & (w_done | m_axi_wready)) state_nxt = WR_RESP;
            WR_RESP: if (m_axi_bvalid) state_nxt = RESP;
            RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axi_rvalid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
        m_axi_awvalid = (state == WR) & ~aw_done;
        m_axi_wvalid = (state == WR) & ~w_done;
        m_axi_bready = (state == WR_RESP);
        m_axi_arvalid = (state == RD_ADDR);
        m_axi_rready = (state == RD_DATA);
        rsp0_valid = (state == RESP) & ~last_grant;
        rsp1_valid = (state == RESP) & last_grant;
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            last_grant <= 1'b1;
            idx_q <= '0;
            wdata_q <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                idx_q <= grant ? req1_idx : req0_idx;
                wdata_q <= grant ? req1_wdata : req0_wdata;
                aw_done <= 1'b0;
                w_done <= 1'b0;
            end
            if (m_axi_awvalid & m_axi_awready) aw_done <= 1'b1;
            if (m_axi_wvalid & m_axi_wready) w_done <= 1'b1;
            if (m_axi_bvalid & m_axi_bready) begin
                rdata_q <= '0;
                err_q <= m_axi_bresp[1];
            end
            if (m_axi_rvalid & m_axi_rready) begin
                rdata_q <= m_axi_rdata;
                err_q <= m_axi_rresp[1];
            end
        end
    end
endmodule

// File: tb/tb_grid_reg_arbiter.sv
// tb_grid_reg_arbiter: directed checks of grid_reg_arbiter against a small AXI4-Lite slave model
module tb_grid_reg_arbiter;
    logic ACLK = 0, ARESETN = 0;
    logic req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [1:0] req0_idx = 0, req1_idx = 0;
    logic [31:0] req0_wdata = 0, req1_wdata = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic [3:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0] m_axi_awprot, m_axi_arprot;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
    logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0] m_axi_wstrb;
    logic [1:0] m_axi_bresp, m_axi_rresp;
    int checks = 0, errors = 0;

    always #5 ACLK = ~ACLK;

    grid_reg_arbiter dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
        .req0_idx(req0_idx), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
        .req1_idx(req1_idx), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // slave model: ready after a programmable wait, one-cycle B/R latency
    logic [31:0] mem [4];
    int aw_delay = 0, w_delay = 0;
    bit rd_err = 0, b_hold = 0;
    int aw_wait = 0, w_wait = 0;
    logic aw_got = 0, w_got = 0, b_pend = 0, ag, wg;
    logic [3:0] aw_a = 0, a;
    logic [31:0] w_d = 0, d;
    assign m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
    assign m_axi_wready = m_axi_wvalid && (w_wait >= w_delay);
    assign m_axi_bvalid = b_pend && !b_hold;
    assign m_axi_bresp = 2'b00;
    assign m_axi_arready = m_axi_arvalid;

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 0; w_got <= 0; b_pend <= 0;
            m_axi_rvalid <= 0; m_axi_rdata <= 0; m_axi_rresp <= 0;
        end else begin
            aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
            w_wait <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
            ag = aw_got || (m_axi_awvalid && m_axi_awready);
            wg = w_got || (m_axi_wvalid && m_axi_wready);
            a = (m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : aw_a;
            d = (m_axi_wvalid && m_axi_wready) ? m_axi_wdata : w_d;
            if (ag && wg) begin
                mem[a[3:2]] <= d; b_pend <= 1; aw_got <= 0; w_got <= 0;
            end else begin
                aw_got <= ag; w_got <= wg; aw_a <= a; w_d <= d;
            end
            if (m_axi_bvalid && m_axi_bready) b_pend <= 0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1;
                m_axi_rdata <= rd_err ? 32'hDEADBEEF : mem[m_axi_araddr[3:2]];
                m_axi_rresp <= rd_err ? 2'b10 : 2'b00;
            end else if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
        end
    end

    // monitor
    int cyc = 0, acc_cyc = 0, aw_hi = 0, w_hi = 0, bready_cyc = -1;
    int rsp0_cnt = 0, rsp1_cnt = 0, both_ready = 0;
    logic [3:0] last_awaddr = 0;
    int grant_q[$];
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            acc_cyc <= cyc; aw_hi <= 0; w_hi <= 0; bready_cyc <= -1;
            grant_q.push_back(req1_ready ? 1 : 0);
        end else begin
            if (m_axi_awvalid) aw_hi <= aw_hi + 1;
            if (m_axi_wvalid) w_hi <= w_hi + 1;
            if (m_axi_bready && bready_cyc < 0) bready_cyc <= cyc;
        end
        if (m_axi_awvalid && m_axi_awready) last_awaddr <= m_axi_awaddr;
        if (rsp0_valid) rsp0_cnt <= rsp0_cnt + 1;
        if (rsp1_valid) rsp1_cnt <= rsp1_cnt + 1;
        if (req0_ready && req1_ready) both_ready <= both_ready + 1;
    end

    task automatic issue(input bit port, input bit wr, input logic [1:0] idx, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        int n;
        @(negedge ACLK);
        if (port) begin req1_valid = 1; req1_write = wr; req1_idx = idx; req1_wdata = wd; end
        else begin req0_valid = 1; req0_write = wr; req0_idx = idx; req0_wdata = wd; end
        n = 0;
        while (!(port ? req1_ready : req0_ready) && n < 50) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        req0_valid = 0; req1_valid = 0;
        lat = 1;
        while (!(port ? rsp1_valid : rsp0_valid) && lat < 50) begin @(negedge ACLK); lat++; end
        rd = port ? rsp1_rdata : rsp0_rdata;
        er = port ? rsp1_err : rsp0_err;
    endtask

    initial begin
        int lat, n, base;
        logic [31:0] rd;
        logic er;
        repeat (3) @(negedge ACLK);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        check("rst_rsp0_err", rsp0_err, 0);
        ARESETN = 1;

        for (int i = 0; i < 4; i++) begin
            issue(0, 1, 2'(i), 32'(i + 1), lat, rd, er);
            check("wr_latency", lat, 3);
            check("wr_awaddr", last_awaddr, 32'(i * 4));
            check("wr_err", er, 0);
            @(negedge ACLK);
            check("wr_pulse_len", rsp0_valid, 0);
        end

        base = rsp0_cnt;
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 2'(i), 0, lat, rd, er);
            check("rd_rdata", rd, 32'(i + 1));
            check("rd_err", er, 0);
            check("rd_latency", lat, 3);
        end
        check("rd_no_rsp0", rsp0_cnt - base, 0);

        aw_delay = 3;
        issue(0, 1, 2'd1, 32'h55, lat, rd, er);
        aw_delay = 0;
        check("awdly_latency", lat, 6);
        check("awdly_awvalid_cycles", aw_hi, 4);
        check("awdly_wvalid_cycles", w_hi, 1);
        check("awdly_bready_rise", bready_cyc - acc_cyc, 5);

        rd_err = 1;
        issue(0, 0, 2'd2, 0, lat, rd, er);
        rd_err = 0;
        check("rerr_rdata", rd, 32'hDEADBEEF);
        check("rerr_err", er, 1);
        issue(0, 0, 2'd2, 0, lat, rd, er);
        check("after_err_rdata", rd, 32'h3);
        check("after_err_err", er, 0);
        check("after_err_latency", lat, 3);

        b_hold = 1;
        @(negedge ACLK);
        req0_valid = 1; req0_write = 1; req0_idx = 3; req0_wdata = 32'h99;
        n = 0;
        while (!req0_ready && n < 20) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        req0_valid = 0;
        n = 0;
        while (!m_axi_bready && n < 20) begin @(negedge ACLK); n++; end
        check("stall_in_wr_resp", m_axi_bready, 1);
        check("stall_rdata_before_rst", rsp0_rdata, 32'h3);
        ARESETN = 0;
        @(negedge ACLK);
        ARESETN = 1; b_hold = 0;
        base = rsp0_cnt + rsp1_cnt;
        check("mid_rst_bready", m_axi_bready, 0);
        check("mid_rst_awvalid", m_axi_awvalid, 0);
        check("mid_rst_wvalid", m_axi_wvalid, 0);
        check("mid_rst_arvalid", m_axi_arvalid, 0);
        check("mid_rst_rready", m_axi_rready, 0);
        check("mid_rst_rsp0_valid", rsp0_valid, 0);
        check("mid_rst_rsp0_rdata", rsp0_rdata, 0);
        check("mid_rst_rsp1_rdata", rsp1_rdata, 0);
        repeat (4) @(negedge ACLK);
        check("mid_rst_no_pulse", rsp0_cnt + rsp1_cnt - base, 0);

        grant_q.delete();
        req0_valid = 1; req0_write = 0; req0_idx = 0;
        req1_valid = 1; req1_write = 0; req1_idx = 1;
        n = 0;
        while (grant_q.size() < 6 && n < 100) begin @(negedge ACLK); n++; end
        req0_valid = 0; req1_valid = 0;
        check("rr_count", grant_q.size(), 6);
        for (int i = 0; i < 6; i++) check("rr_order", grant_q.size() > i ? grant_q[i] : -1, i % 2);
        repeat (5) @(negedge ACLK);
        check("rr_no_dual_ready", both_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
